// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MD_UNIT_MADD_EN to enable the accumulate ops (madd/maddu/msub/msubu).
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       hilo_op,
    input  logic [1:0]       whilo,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic              op_legal;
    logic              is_div;
    logic              signed_op;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]  div_safe, quot, rem;
    logic signed [WIDTH-1:0] quot_s, rem_s;
    logic [WIDTH-1:0]  res_hi, res_lo;

    always_comb begin
`ifdef MD_UNIT_MADD_EN
        op_legal = 1'b1;
`else
        op_legal = ~hilo_op[2];
`endif
        is_div = (hilo_op[2:1] == 2'b01);
    end

    // Extending both operands to 2*WIDTH lets one unsigned multiplier serve both signednesses.
    always_comb begin
        signed_op = ~op_q[0];
        a_ext     = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q};
        b_ext     = {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
        prod      = a_ext * b_ext;
    end

    // A zero divisor is swapped for 1 so the divider never sees it; the result is discarded anyway.
    always_comb begin
        div_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        quot_s   = $signed(a_q) / $signed(div_safe);
        rem_s    = $signed(a_q) % $signed(div_safe);
        quot     = op_q[0] ? (a_q / div_safe) : quot_s;
        rem      = op_q[0] ? (a_q % div_safe) : rem_s;
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            3'b000, 3'b001: {res_hi, res_lo} = prod;
            3'b010, 3'b011: begin
                if (b_q != '0) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
`ifdef MD_UNIT_MADD_EN
            3'b100, 3'b101: {res_hi, res_lo} = {hi_q, lo_q} + prod;
            3'b110, 3'b111: {res_hi, res_lo} = {hi_q, lo_q} - prod;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start && op_legal) begin
                    op_d    = hilo_op;
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = is_div ? DivLoad : MultLoad;
                    state_d = StBusy;
                end else if (whilo == 2'b00) begin
                    hi_d = rs_val;
                end else if (whilo == 2'b01) begin
                    lo_d = rs_val;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
